serial_addsub_ctrl: RTL and testbench



---
 rtl/alu_pkg.sv | 7 +
 rtl/rc_adder.sv | 11 +
 rtl/serial_addsub_ctrl.sv | 89 ++++++++
 tb/tb_serial_addsub_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU types and constants for the serial add/sub sequencer and decoder
package alu_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int SLICE_W = 2;
  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;
endpackage

// File: rtl/rc_adder.sv
// rc_adder: SLICE_W-bit ripple-carry add/sub slice, b inverted when mode is high
module rc_adder import alu_pkg::*; (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               c_in,
  input  logic               mode,
  output logic [SLICE_W-1:0] sum,
  output logic               c_out
);
  assign {c_out, sum} = {1'b0, a} + {1'b0, b ^ {SLICE_W{mode}}} + {{SLICE_W{1'b0}}, c_in};
endmodule

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: sequences a WIDTH-bit add/sub through one rc_adder slice, LSB first
module serial_addsub_ctrl import alu_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH / SLICE_W);
  localparam logic [CW-1:0] LAST = CW'(WIDTH / SLICE_W - 1);
  state_t state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CW-1:0] cnt;
  logic [SLICE_W-1:0] sum;
  logic mode_r, carry, a_msb, b_msb, slice_c;
  rc_adder u_slice (
    .a(a_sh[SLICE_W-1:0]),
    .b(b_sh[SLICE_W-1:0]),
    .c_in(carry),
    .mode(mode_r),
    .sum(sum),
    .c_out(slice_c)
  );
  assign c_out = carry;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      mode_r    <= 1'b0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_sh     <= a;
            b_sh     <= b;
            mode_r   <= mode;
            a_msb    <= a[WIDTH-1];
            b_msb    <= b[WIDTH-1];
            carry    <= mode;
            cnt      <= '0;
            result   <= '0;
            ovf      <= 1'b0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          result <= {sum, result[WIDTH-1:SLICE_W]};
          carry  <= slice_c;
          a_sh   <= a_sh >> SLICE_W;
          b_sh   <= b_sh >> SLICE_W;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            out_valid <= 1'b1;
            ovf       <= (a_msb == (b_msb ^ mode_r)) && (sum[SLICE_W-1] != a_msb);
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb_serial_addsub_ctrl: randomized and directed checks of serial_addsub_ctrl at WIDTH 8 and 16
module tb_serial_addsub_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] a_in, b_in;
  logic mode;
  logic iv8, or8, ir8, ov8, co8, of8;
  logic iv16, or16, ir16, ov16, co16, of16;
  logic [7:0] res8;
  logic [15:0] res16;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  serial_addsub_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a_in[7:0]), .b(b_in[7:0]),
    .mode(mode), .out_valid(ov8), .out_ready(or8), .result(res8), .c_out(co8), .ovf(of8)
  );
  serial_addsub_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a_in), .b(b_in),
    .mode(mode), .out_valid(ov16), .out_ready(or16), .result(res16), .c_out(co16), .ovf(of16)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic get_ir(input int w);
    return w == 8 ? ir8 : ir16;
  endfunction
  function automatic logic get_ov(input int w);
    return w == 8 ? ov8 : ov16;
  endfunction
  function automatic logic get_co(input int w);
    return w == 8 ? co8 : co16;
  endfunction
  function automatic logic get_of(input int w);
    return w == 8 ? of8 : of16;
  endfunction
  function automatic logic [15:0] get_res(input int w);
    return w == 8 ? {8'h00, res8} : res16;
  endfunction
  task automatic set_iv(input int w, input logic v);
    if (w == 8) iv8 = v;
    else iv16 = v;
  endtask
  task automatic set_or(input int w, input logic v);
    if (w == 8) or8 = v;
    else or16 = v;
  endtask
  // Reference: plain integer arithmetic, overflow from the true signed result leaving range
  task automatic model(input int w, input logic [15:0] av, input logic [15:0] bv, input logic m,
                       output logic [15:0] r, output logic c, output logic o);
    longint m2, ua, ub, sa, sb, raw, s;
    m2 = longint'(1) << w;
    ua = longint'(av);
    ub = longint'(bv);
    sa = av[w-1] ? ua - m2 : ua;
    sb = bv[w-1] ? ub - m2 : ub;
    if (m) begin
      raw = ua - ub;
      c = ua >= ub;
      s = sa - sb;
    end else begin
      raw = ua + ub;
      c = raw >= m2;
      s = sa + sb;
    end
    r = 16'((raw + m2) % m2);
    o = (s < -(m2 / 2)) || (s >= m2 / 2);
  endtask
  task automatic xact(input int w, input logic [15:0] av, input logic [15:0] bv, input logic m,
                      input int stall);
    logic [15:0] er;
    logic ec, eo;
    int t;
    model(w, av, bv, m, er, ec, eo);
    a_in = av;
    b_in = bv;
    mode = m;
    set_or(w, stall == 0);
    set_iv(w, 1'b1);
    t = 0;
    while (!get_ir(w) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!get_ir(w)) check("in_ready_timeout", get_ir(w), 1);
    @(negedge clk);
    set_iv(w, 1'b0);
    t = 1;
    while (!get_ov(w) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("latency", t, w / 2 + 1);
    check("result", get_res(w), er);
    check("c_out", get_co(w), ec);
    check("ovf", get_of(w), eo);
    check("ready_in_done", get_ir(w), 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", get_ov(w), 1);
      check("stall_result", get_res(w), er);
    end
    set_or(w, 1'b1);
    @(negedge clk);
    check("release_valid", get_ov(w), 0);
    check("release_ready", get_ir(w), 1);
  endtask
  initial begin
    logic [15:0] av, bv, mask;
    int t, seen;
    rst_n = 1'b0;
    iv8 = 1'b0; iv16 = 1'b0; or8 = 1'b1; or16 = 1'b1;
    a_in = '0; b_in = '0; mode = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", ir8, 0);
    check("rst_out_valid", ov8, 0);
    check("rst_result", res8, 0);
    check("rst_c_out", co8, 0);
    check("rst_ovf", of8, 0);
    check("rst_in_ready16", ir16, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", ir8, 1);
    check("post_rst_valid", ov8, 0);
    xact(8, 16'h5A, 16'h3C, 1'b0, 0);
    check("add_5a_3c", res8, 8'h96);
    xact(8, 16'h10, 16'h20, 1'b1, 0);
    check("sub_borrow", res8, 8'hF0);
    xact(8, 16'hFF, 16'h01, 1'b0, 0);
    check("wrap_carry", co8, 1);
    xact(8, 16'h80, 16'h01, 1'b1, 0);
    check("sub_ovf", of8, 1);
    // Backpressure with a second request waiting for in_ready
    a_in = 16'h33; b_in = 16'h11; mode = 1'b0; or8 = 1'b0; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    t = 0;
    while (!ov8 && t < 50) begin
      @(negedge clk);
      t++;
    end
    a_in = 16'h44; b_in = 16'h22; mode = 1'b1; iv8 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", ov8, 1);
      check("bp_ready", ir8, 0);
      check("bp_result", res8, 8'h44);
      @(negedge clk);
    end
    or8 = 1'b1;
    @(negedge clk);
    check("bp_release_ready", ir8, 1);
    check("bp_release_valid", ov8, 0);
    xact(8, 16'h44, 16'h22, 1'b1, 0);
    check("bp_next_result", res8, 8'h22);
    // Reset during the second RUN cycle
    a_in = 16'h55; b_in = 16'h66; mode = 1'b0; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_ready", ir8, 0);
    check("mid_rst_valid", ov8, 0);
    check("mid_rst_result", res8, 0);
    check("mid_rst_c_out", co8, 0);
    check("mid_rst_ovf", of8, 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ov8) seen++;
    end
    check("mid_rst_no_valid", seen, 0);
    xact(8, 16'h01, 16'h01, 1'b0, 0);
    check("after_rst_result", res8, 8'h02);
    xact(16, 16'h7FFF, 16'h0001, 1'b0, 2);
    xact(16, 16'h0000, 16'h0001, 1'b1, 0);
    for (int w = 8; w <= 16; w += 8) begin
      mask = (w == 8) ? 16'h00FF : 16'hFFFF;
      for (int n = 0; n < 1000; n++) begin
        av = 16'($urandom) & mask;
        bv = 16'($urandom) & mask;
        xact(w, av, bv, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  always @(negedge clk) begin
    if (rst_n && ((ov8 && ir8) || (ov16 && ir16))) begin
      errors++;
      $display("FAIL handshake_exclusive: out_valid and in_ready both high at %0t", $time);
    end
  end
endmodule
